// File: rtl/cargador_ram.sv
// Column-RAM writer for the POV display: turns a header-framed byte stream into
// consecutive 16-bit column writes and flags when a full frame is stored.
module cargador_ram #(
    parameter int          NUM_COL = 128,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dato_in,
    input  logic        dato_valid,
    output logic        we,
    output logic [7:0]  dir,
    output logic [15:0] dato_ram,
    output logic        ocupado,
    output logic        listo,
    output logic        error
);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        BYTE_ALTO = 2'd1,
        BYTE_BAJO = 2'd2,
        FIN       = 2'd3
    } estado_t;

    // Last column index and the idle count at which the next idle cycle aborts.
    localparam logic [7:0]  ULTIMA = 8'(NUM_COL - 1);
    localparam logic [23:0] LIMITE = 24'(TIMEOUT - 1);

    estado_t     state;
    logic [7:0]  col;
    logic [23:0] cnt;
    logic [7:0]  alto;

    // Frame loader FSM: header detection, byte pairing, RAM write and timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ESPERA;
            col      <= 8'd0;
            cnt      <= 24'd0;
            alto     <= 8'd0;
            we       <= 1'b0;
            dir      <= 8'd0;
            dato_ram <= 16'd0;
            listo    <= 1'b0;
            error    <= 1'b0;
        end else begin
            we    <= 1'b0;
            error <= 1'b0;
            case (state)
                ESPERA: begin
                    if (dato_valid && (dato_in == HEADER)) begin
                        state <= BYTE_ALTO;
                        col   <= 8'd0;
                        cnt   <= 24'd0;
                        listo <= 1'b0;
                    end
                end
                BYTE_ALTO: begin
                    if (dato_valid) begin
                        alto  <= dato_in;
                        cnt   <= 24'd0;
                        state <= BYTE_BAJO;
                    end else if (cnt == LIMITE) begin
                        error <= 1'b1;
                        cnt   <= 24'd0;
                        state <= ESPERA;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                BYTE_BAJO: begin
                    if (dato_valid) begin
                        dato_ram <= {alto, dato_in};
                        dir      <= col;
                        we       <= 1'b1;
                        cnt      <= 24'd0;
                        // Stopping at the last column keeps col from wrapping at 256.
                        if (col == ULTIMA) begin
                            state <= FIN;
                        end else begin
                            col   <= col + 8'd1;
                            state <= BYTE_ALTO;
                        end
                    end else if (cnt == LIMITE) begin
                        error <= 1'b1;
                        cnt   <= 24'd0;
                        state <= ESPERA;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                FIN: begin
                    listo <= 1'b1;
                    state <= ESPERA;
                end
                default: begin
                    state <= ESPERA;
                end
            endcase
        end
    end

    assign ocupado = (state != ESPERA);

endmodule

// File: tb/tb_cargador_ram.sv
// Randomized scoreboard bench for cargador_ram: a frame-level reference model
// predicts writes, ready rises and timeout pulses; a negedge monitor compares them.
module tb_cargador_ram;

    localparam int         NCOL = 4;
    localparam int         TOUT = 50;
    localparam logic [7:0] HDR  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dato_in = 8'd0;
    logic        dato_valid = 1'b0;
    logic        we;
    logic [7:0]  dir;
    logic [15:0] dato_ram;
    logic        ocupado;
    logic        listo;
    logic        error;

    cargador_ram #(.NUM_COL(NCOL), .HEADER(HDR), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valid(dato_valid),
        .we(we), .dir(dir), .dato_ram(dato_ram), .ocupado(ocupado),
        .listo(listo), .error(error)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct { int cyc; logic [7:0] a; logic [15:0] d; } wr_t;
    wr_t wq[$];
    int  lq[$];
    int  eq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: frame-level view of the loader
    bit         m_act = 0;
    bit         m_hh = 0;
    logic [7:0] m_hi = 8'd0;
    int         m_col = 0;
    int         m_idle = 0;
    int         m_fin = -1;

    task automatic model(input int k, input logic r, input logic v, input logic [7:0] b);
        if (r) begin
            m_act = 0; m_hh = 0; m_idle = 0; m_fin = -1;
        end else if (m_act) begin
            if (v) begin
                m_idle = 0;
                if (!m_hh) begin
                    m_hi = b; m_hh = 1;
                end else begin
                    wq.push_back('{k, 8'(m_col), {m_hi, b}});
                    m_hh = 0;
                    if (m_col == NCOL - 1) begin
                        m_act = 0; m_fin = k + 1; lq.push_back(k + 1);
                    end else begin
                        m_col++;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TOUT) begin
                    eq.push_back(k); m_act = 0;
                end
            end
        end else if (v && (k != m_fin) && (b == HDR)) begin
            m_act = 1; m_col = 0; m_hh = 0; m_idle = 0;
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [7:0] b);
        rst = r; dato_valid = v; dato_in = b;
        model(edge_n + 1, r, v, b);
        @(posedge clk); #1;
        dato_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        tick(1'b0, 1'b1, b);
        idle(gap);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    logic listo_prev = 1'b0;
    always @(negedge clk) begin
        if (we) begin
            if (wq.size() == 0) chk("unexpected_we", 32'(dir), 32'hFFFF_FFFF);
            else begin
                wr_t w;
                w = wq.pop_front();
                chk("we_cycle", 32'(edge_n), 32'(w.cyc));
                chk("dir", 32'(dir), 32'(w.a));
                chk("dato_ram", 32'(dato_ram), 32'(w.d));
            end
        end
        if (error) begin
            if (eq.size() == 0) chk("unexpected_error", 32'(edge_n), 32'hFFFF_FFFF);
            else chk("error_cycle", 32'(edge_n), 32'(eq.pop_front()));
            chk("ocupado_at_error", 32'(ocupado), 32'd0);
            chk("listo_at_error", 32'(listo), 32'd0);
        end
        if (listo && !listo_prev) begin
            if (lq.size() == 0) chk("unexpected_listo", 32'(edge_n), 32'hFFFF_FFFF);
            else chk("listo_cycle", 32'(edge_n), 32'(lq.pop_front()));
            chk("ocupado_at_listo", 32'(ocupado), 32'd0);
        end
        listo_prev = listo;
    end

    logic [7:0] frame_a [8];
    logic [7:0] bb;
    int         r;

    initial begin
        frame_a[0] = 8'h12; frame_a[1] = 8'h34; frame_a[2] = 8'h56; frame_a[3] = 8'h78;
        frame_a[4] = 8'h9A; frame_a[5] = 8'hBC; frame_a[6] = 8'hDE; frame_a[7] = 8'hF0;

        tick(1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b1, HDR);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_dato_ram", 32'(dato_ram), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_listo", 32'(listo), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        idle(2);

        // Noise then a full frame with gaps
        send(8'h00, 1); send(8'hFF, 0); send(8'h12, 2);
        send(HDR, 0);
        chk("ocupado_after_hdr", 32'(ocupado), 32'd1);
        for (int i = 0; i < 8; i++) send(frame_a[i], 1);
        idle(4);
        chk("listo_after_frame", 32'(listo), 32'd1);
        chk("ocupado_after_frame", 32'(ocupado), 32'd0);

        // Back-to-back, with header value as data
        send(HDR, 0);
        send(HDR, 0); send(8'h01, 0);
        for (int i = 2; i < 8; i++) send(frame_a[i], 0);
        idle(4);

        // Timeout
        send(HDR, 0); send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
        idle(TOUT + 5);
        chk("listo_after_timeout", 32'(listo), 32'd0);
        chk("ocupado_after_timeout", 32'(ocupado), 32'd0);
        send(HDR, 1);
        for (int i = 0; i < 8; i++) send(frame_a[i], 0);
        idle(4);

        // Reset while waiting for a low byte
        send(HDR, 0); send(8'h11, 0);
        tick(1'b1, 1'b1, 8'h22);
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
        chk("mid_rst_listo", 32'(listo), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'd0);
        chk("mid_rst_dato_ram", 32'(dato_ram), 32'd0);
        idle(2);
        send(HDR, 0);
        for (int i = 0; i < 8; i++) send(frame_a[7 - i], 0);
        idle(3);
        chk("listo_before_relaunch", 32'(listo), 32'd1);
        send(HDR, 0);
        chk("listo_cleared_by_hdr", 32'(listo), 32'd0);
        for (int i = 0; i < 8; i++) send(frame_a[i], 1);
        idle(4);

        // Randomized traffic including timeouts and bytes dropped in FIN
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                idle(TOUT + 3);
            end else if (r < 65) begin
                bb = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom_range(0, 255));
                tick(1'b0, 1'b1, bb);
            end else begin
                idle(1);
            end
        end
        idle(TOUT + 10);

        chk("writes_pending", 32'(wq.size()), 32'd0);
        chk("listo_pending", 32'(lq.size()), 32'd0);
        chk("error_pending", 32'(eq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
